// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - serial_tx states and line levels; SERIAL_TX_PARITY_EN adds the PARITY state
package serial_tx_pkg;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// rtl/serial_tx_bit_timer.sv - counts CLKS_PER_BIT cycles per serial bit and flags the last one
module serial_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_done_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Free-running bit-period counter, restarted whenever the FSM changes state
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_done_o = (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - parallel-to-serial frame transmitter; define SERIAL_TX_PARITY_EN for an even-parity bit
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bitcnt;
  logic              bit_done;
  logic              accept;
  logic              last_bit;
  logic              state_change;
`ifdef SERIAL_TX_PARITY_EN
  logic              par;
`endif

  assign accept   = (state == IDLE) && valid_i && ready_o;
  assign last_bit = (bitcnt == LAST_BIT);
  // Every non-IDLE state leaves on bit_done, except DATA which stays until its last bit
  assign state_change = accept ||
                        (bit_done && (state != IDLE) && ((state != DATA) || last_bit));

  serial_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (state_change),
    .bit_done_o (bit_done)
  );

  // Frame sequencer; tx_o/ready_o/busy_o are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_o    <= IDLE_LEVEL;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
      shreg   <= '0;
      bitcnt  <= '0;
`ifdef SERIAL_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_o    <= IDLE_LEVEL;
          busy_o  <= 1'b0;
          ready_o <= 1'b1;
          if (accept) begin
            state   <= START;
            tx_o    <= START_LEVEL;
            busy_o  <= 1'b1;
            ready_o <= 1'b0;
            shreg   <= data_i;
            bitcnt  <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par     <= ^data_i;
`endif
          end
        end
        START: begin
          if (bit_done) begin
            state  <= DATA;
            tx_o   <= shreg[0];
            bitcnt <= '0;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
              state <= PARITY;
              tx_o  <= par;
`else
              state <= STOP;
              tx_o  <= IDLE_LEVEL;
`endif
            end else begin
              shreg  <= {1'b0, shreg[DATA_W-1:1]};
              tx_o   <= shreg[1];
              bitcnt <= bitcnt + BW'(1);
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state <= STOP;
            tx_o  <= IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            state   <= IDLE;
            tx_o    <= IDLE_LEVEL;
            busy_o  <= 1'b0;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx_o    <= IDLE_LEVEL;
          busy_o  <= 1'b0;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - scoreboard bench for serial_tx (honours SERIAL_TX_PARITY_EN)
module tb_serial_tx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS  = DATA_W + 3;
`else
  localparam int NBITS  = DATA_W + 2;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       tx;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frames_seen = 0;

  typedef struct {
    logic [7:0] word;
    int         push_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   collecting = 0;
  bit   post = 0;
  int   idx = 0;
  int   bad_idx = -1;

  serial_tx #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data),
    .valid_i (valid),
    .ready_o (ready),
    .tx_o    (tx),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Line level expected i cycles into a frame carrying d
  function automatic logic model_level(input logic [7:0] d, input int i);
    int b;
    b = i / CPB;
    if (b == 0) return 1'b0;
    if (b <= DATA_W) return d[b-1];
`ifdef SERIAL_TX_PARITY_EN
    if (b == DATA_W + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // Record every accepted word
  always @(negedge clk) begin
    if (!rst && valid === 1'b1 && ready === 1'b1) begin
      exp_t e;
      e.word = data;
      e.push_cyc = cyc;
      exp_q.push_back(e);
    end
  end

  // Decode the serial line and compare against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      collecting = 0;
      post = 0;
    end else if (post) begin
      post = 0;
      check("post_ready", {31'd0, ready}, 32'd1);
      check("post_tx", {31'd0, tx}, 32'd1);
      check("post_busy", {31'd0, busy}, 32'd0);
    end else if (!collecting && tx === 1'b0) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        check("start_delay", cyc - cur.push_cyc, 32'd1);
        collecting = 1;
        idx = 0;
        bad_idx = -1;
      end
    end
    if (collecting && !rst) begin
      if ((tx !== model_level(cur.word, idx) || busy !== 1'b1 || ready !== 1'b0) && bad_idx < 0)
        bad_idx = idx;
      idx++;
      if (idx == FRAME_CYC) begin
        collecting = 0;
        post = 1;
        checks++;
        if (bad_idx >= 0) begin
          errors++;
          $display("FAIL frame %02h: first wrong cycle %0d (tx=%b busy=%b ready=%b), required none",
                   cur.word, bad_idx, tx, busy, ready);
        end
      end
    end
  end

  task automatic send(input logic [7:0] w);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_wait_timeout", {31'd0, ready !== 1'b1}, 32'd0);
    data = w;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    data = 8'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((collecting || post || exp_q.size() != 0 || ready !== 1'b1) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_timeout", {31'd0, n >= 500}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dir_words [4];
    int f0;
    dir_words[0] = 8'hA5;
    dir_words[1] = 8'h07;
    dir_words[2] = 8'h03;
    dir_words[3] = 8'h00;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {31'd0, ready}, 32'd1);
    check("idle_tx", {31'd0, tx}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Directed single frames
    for (int i = 0; i < 4; i++) begin
      send(dir_words[i]);
      wait_done();
    end

    // Input ignored while busy
    send(8'h3C);
    repeat (11) begin @(posedge clk); #1; end
    valid = 1'b1;
    data = 8'hFF;
    @(posedge clk); #1;
    valid = 1'b0;
    wait_done();
    f0 = frames_seen;
    repeat (50) begin @(posedge clk); #1; end
    check("ignored_no_frame", frames_seen - f0, 32'd0);

    // Back-to-back with valid held high
    begin
      int n;
      data = 8'h01;
      valid = 1'b1;
      @(posedge clk); #1;
      data = 8'h80;
      n = 0;
      while (ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
      check("b2b_timeout", {31'd0, n >= 200}, 32'd0);
      @(posedge clk); #1;
      valid = 1'b0;
      wait_done();
    end

    // Randomized frames with occasional junk while busy
    for (int i = 0; i < 12; i++) begin
      send(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 30)) begin @(posedge clk); #1; end
        valid = 1'b1;
        data = 8'($urandom);
        @(posedge clk); #1;
        valid = 1'b0;
      end
      wait_done();
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    // Reset in the middle of a frame
    send(8'h5A);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    f0 = frames_seen;
    @(posedge clk); #1;
    check("abort_ready_back", {31'd0, ready}, 32'd1);
    repeat (60) begin @(posedge clk); #1; end
    check("abort_no_retx", frames_seen - f0, 32'd0);
    check("abort_tx_idle", {31'd0, tx}, 32'd1);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
- REQ-001: Parameter DATA_W, 8: data bits per frame, range 5..16.
- REQ-002: Parameter CLKS_PER_BIT, 4: clk cycles per serial bit, minimum 2.
- REQ-003: Port clk, input, 1: single clock; all state changes on its rising edge.
- REQ-004: Port rst, input, 1: reset, synchronous and active-high.
- REQ-005: Port data_i, input, DATA_W: parallel word to transmit.
- REQ-006: Port valid_i, input, 1: data_i is valid.
- REQ-007: Port ready_o, output, 1: block accepts a word this cycle.
- REQ-008: Port tx_o, output, 1: serial line, idle high.
- REQ-009: Port busy_o, output, 1: a frame is in progress.

Function
- REQ-010: A word SHALL be accepted only on a rising edge where valid_i and ready_o are both 1; data_i is latched into a shift register on that edge.
- REQ-011: ready_o SHALL be 1 only in IDLE; it is a registered output, never combinationally dependent on valid_i.
- REQ-012: The state machine SHALL have states IDLE, START, DATA, PARITY, STOP.
- REQ-013: IDLE: tx_o=1, busy_o=0; on accept, go to START in the next cycle.
- REQ-014: START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
- REQ-015: DATA: tx_o carries shift-register bit 0, LSB first; each bit lasts CLKS_PER_BIT cycles; after DATA_W bits, go to PARITY if compiled in, otherwise to STOP.
- REQ-016: STOP: tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE; ready_o becomes 1 in the cycle after STOP ends.
- REQ-017: Latency SHALL be exactly 1 cycle from the accept edge to the first tx_o=0.
- REQ-018: Frame length SHALL be (DATA_W+2) or (DATA_W+3)*CLKS_PER_BIT cycles, without and with parity respectively.
- REQ-019: busy_o SHALL be 1 in START, DATA, PARITY and STOP.
- REQ-020: valid_i asserted while busy_o=1 SHALL be ignored; data_i changes mid-frame SHALL NOT affect the frame.
- REQ-021: Back-to-back: with valid_i held high, the next START SHALL begin 1 cycle after ready_o returns high, giving exactly one idle-high cycle between frames.
- REQ-022: The bit counter SHALL be ceil(log2(DATA_W+1)) bits wide; the cycle counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and wrap to 0 at CLKS_PER_BIT-1.

Reset
- REQ-023: While rst=1 at a rising edge: state=IDLE, tx_o=1, ready_o=0, busy_o=0, counters=0, shift register=0.
- REQ-024: ready_o SHALL rise on the first edge with rst=0.
- REQ-025: Reset asserted mid-frame SHALL abort the frame at the next edge, with tx_o=1 and no partial-bit extension; the aborted word is not retransmitted.

Configuration
- REQ-026: Macro SERIAL_TX_PARITY_EN: when defined, the PARITY state SHALL transmit the even-parity bit (XOR of all data bits) for CLKS_PER_BIT cycles. When undefined, the PARITY state and the parity logic SHALL be absent, and DATA goes directly to STOP.

Structure
- REQ-027: Package serial_tx_pkg SHALL hold the state enum type (tx_state_t) and the constants IDLE_LEVEL=1'b1 and START_LEVEL=1'b0.
- REQ-028: One sub-module, serial_tx_bit_timer, SHALL count CLKS_PER_BIT cycles and pulse bit_done_o; it is cleared on rst and on a state change.

Verification (DATA_W=8, CLKS_PER_BIT=4)
- REQ-029: Reset: hold rst=1 for 3 cycles, then release -> tx_o=1 and busy_o=0 throughout; ready_o=1 from the first edge with rst=0.
- REQ-030: Single frame, no parity: data_i=8'hA5, valid_i pulsed 1 cycle -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; 40-cycle frame; ready_o high at cycle 41.
- REQ-031: Parity, SERIAL_TX_PARITY_EN defined: data_i=8'h07 -> parity bit 1 after the data bits; 44-cycle frame. data_i=8'h03 -> parity bit 0.
- REQ-032: Back-to-back: valid_i held high with 8'h01 then 8'h80 -> two complete frames separated by exactly one idle-high cycle.
- REQ-033: Ignored input: send 8'h3C, then assert valid_i with 8'hFF at cycle 12 -> frame carries 8'h3C unchanged; 8'hFF is not transmitted.
- REQ-034: Mid-frame reset: rst=1 for 1 cycle at cycle 20 of a frame -> tx_o=1 and state=IDLE on the next edge; ready_o=1 on the edge after rst drops.
